// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths and fetch/decode types
package cpu_pkg;
  localparam int PC_W = 16;
  localparam int INSTR_W = 16;
  localparam logic [PC_W-1:0] DEFAULT_PC_STEP = 16'd4;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with push/pop/clear and occupancy
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t pushData,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  always_ff @(posedge clk)
    if (push && !clear) mem[wrPtr] <= pushData;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(push);
      rdPtr <= rdPtr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = count == '0 ? '0 : mem[rdPtr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue owning the fetch PC and in-flight read
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [PC_W-1:0] PC_STEP = DEFAULT_PC_STEP
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     dec_valid,
  output logic [INSTR_W-1:0]       dec_instr,
  output logic [PC_W-1:0]          dec_pc,
  input  logic                     dec_ready,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [PC_W-1:0] fetchPc, inflightPc, reqPc;
  logic inflight, issue;
  fetch_entry_t head, pushData;
  assign reqPc = redirect ? redirect_pc : fetchPc;
  // space is reserved for the in-flight read; a same-cycle pop earns no credit
  assign issue = redirect || ({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH);
  assign imem_req = reset && issue;
  assign imem_addr = reset ? reqPc : RESET_PC;
  assign dec_valid = count != '0;
  assign dec_pc = head.pc;
  assign dec_instr = head.instr;
  assign pushData = '{pc: inflightPc, instr: imem_rdata};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetchPc <= RESET_PC;
      inflight <= 1'b0;
      inflightPc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetchPc <= reqPc + PC_STEP;
        inflightPc <= reqPc;
      end
    end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (redirect),
    .push     (inflight && !redirect),
    .pop      (dec_valid && dec_ready && !redirect),
    .pushData (pushData),
    .head     (head),
    .count    (count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench against a queue-based fetch model
module tb_fetch_queue;
  import cpu_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
  logic clk = 0, reset = 0;
  logic imem_req, dec_valid, dec_ready = 0, redirect = 0;
  logic [15:0] imem_addr, imem_rdata = 0, dec_instr, dec_pc, redirect_pc = 0;
  logic [$clog2(DEPTH):0] count;
  int total = 0, bad = 0;
  fetch_entry_t mq[$];
  logic mInf = 0, pendReq = 0;
  logic [15:0] mInfPc = 0, mNext = RESET_PC, pendAddr = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(16'd4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_ready(dec_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(logic [15:0] a);
    return 16'h1000 + (a >> 2);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction memory: answers exactly one cycle after the request, garbage otherwise
  always @(posedge clk) begin
    #1;
    imem_rdata = pendReq ? memWord(pendAddr) : 16'($urandom);
  end

  // monitor: compare DUT outputs with the model mid-cycle, then advance the model
  always @(negedge clk) begin
    logic expReq, v;
    logic [15:0] expAddr;
    fetch_entry_t e;
    if (!reset) begin
      mq.delete();
      mInf = 0;
      mNext = RESET_PC;
      pendReq = 0;
    end else begin
      expReq = redirect || (mq.size() + int'(mInf) < DEPTH);
      expAddr = redirect ? redirect_pc : mNext;
      v = mq.size() != 0;
      chk("imem_req", 32'(imem_req), 32'(expReq));
      if (expReq) chk("imem_addr", 32'(imem_addr), 32'(expAddr));
      chk("dec_valid", 32'(dec_valid), 32'(v));
      chk("dec_pc", 32'(dec_pc), v ? 32'(mq[0].pc) : 32'd0);
      chk("dec_instr", 32'(dec_instr), v ? 32'(mq[0].instr) : 32'd0);
      chk("count", 32'(count), 32'(mq.size()));
      pendReq = imem_req;
      pendAddr = imem_addr;
      if (redirect) mq.delete();
      else begin
        if (v && dec_ready) void'(mq.pop_front());
        if (mInf) begin
          e.pc = mInfPc;
          e.instr = memWord(mInfPc);
          mq.push_back(e);
        end
      end
      mInf = expReq;
      if (expReq) begin
        mInfPc = expAddr;
        mNext = expAddr + 16'd4;
      end
    end
  end

  task automatic cyc(logic rdy, logic rd, logic [15:0] rpc);
    @(posedge clk);
    #1;
    dec_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
  endtask

  task automatic chkCleared(string tag);
    chk({tag, "_req"}, 32'(imem_req), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(RESET_PC));
    chk({tag, "_valid"}, 32'(dec_valid), 0);
    chk({tag, "_instr"}, 32'(dec_instr), 0);
    chk({tag, "_pc"}, 32'(dec_pc), 0);
    chk({tag, "_count"}, 32'(count), 0);
  endtask

  initial begin
    #3;
    chkCleared("rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    repeat (20) cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    repeat (10) cyc(1, 0, 0);
    repeat (8) cyc(0, 0, 0);
    cyc(0, 1, 16'h0200);
    repeat (6) cyc(1, 0, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 16'h0300);
    repeat (4) cyc(1, 0, 0);
    cyc(0, 1, 16'hFFFC);
    repeat (6) cyc(0, 0, 0);
    repeat (12) cyc(1'($urandom % 2), 0, 0);
    repeat (2000) cyc($urandom % 4 != 0, $urandom % 16 == 0, 16'($urandom) & 16'hFFFC);
    @(posedge clk);
    #3;
    redirect = 0;
    reset = 0;
    #1;
    chkCleared("async");
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    repeat (300) cyc($urandom % 3 != 0, $urandom % 20 == 0, 16'($urandom) & 16'hFFFC);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the decode/register-fetch stage. It owns the fetch PC, issues one instruction-memory read per cycle while buffer space allows, and buffers returned instructions with their PCs in a small FIFO. Decode pops `{pc, instr}` pairs with a valid/ready handshake. A branch redirect from execute flushes the queue and any in-flight read.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `RESET_PC`, 16'h0000: first fetch address after reset.
- `PC_STEP`, 16'd4: byte increment between sequential fetches.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request to instruction memory this cycle.
- `imem_addr`  out  16  read address; valid when `imem_req`=1.
- `imem_rdata`  in  16  instruction; valid exactly one cycle after the matching request.
- `dec_valid`  out  1  queue head is valid.
- `dec_instr`  out  16  head instruction; 16'h0000 when empty.
- `dec_pc`  out  16  head PC; 16'h0000 when empty.
- `dec_ready`  in  1  decode accepts head this cycle.
- `redirect`  in  1  branch taken; flush and refetch.
- `redirect_pc`  in  16  new fetch address.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: `fetch_pc`, `inflight` (1 bit), `inflight_pc`, FIFO rd/wr pointers, `count`.
- Request rule, no redirect: `imem_req` = (`count` + `inflight`) < DEPTH, using registered values; a same-cycle pop is not credited. `imem_addr` = `fetch_pc`. On issue: `fetch_pc` += PC_STEP (mod 2^16), `inflight`←1, `inflight_pc`←`fetch_pc`. Otherwise `inflight`←0.
- Response: if `inflight`=1 and no redirect, `{inflight_pc, imem_rdata}` is written at the tail.
- Pop: when `dec_valid` && `dec_ready` and no redirect, head is retired.
- Push and pop in the same cycle: `count` is unchanged. This is legal at full, because a push only exists if space was reserved.
- Redirect has top priority:
  - FIFO is cleared and `count`←0.
  - The response arriving this cycle is discarded.
  - Any pop this cycle is ignored.
  - `imem_req`=1 and `imem_addr`=`redirect_pc` combinationally in the same cycle.
  - `fetch_pc`←`redirect_pc`+PC_STEP, `inflight`←1, `inflight_pc`←`redirect_pc`.
- Pointers wrap modulo DEPTH. `fetch_pc` wraps modulo 2^16.
- Reset (asynchronous, any time, including mid-stream or mid-redirect):
  - `fetch_pc`←RESET_PC; `count`, pointers and `inflight` cleared.
  - Outputs `imem_req`=0, `imem_addr`=RESET_PC, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, `count`=0.

## Timing
- First request is in the first rising-edge cycle after `reset` deasserts (cycle 0), at RESET_PC.
- Request-to-`dec_valid` latency is 2 cycles: request in cycle N, data returns N+1, head is visible N+2.
- Redirect in cycle N: `dec_valid`=0 in N+1; instruction at `redirect_pc` is visible in N+2.
- Sustained throughput with `dec_ready`=1 is one instruction per cycle; occupancy stays ≤ 1.
- Decode outputs are driven from FIFO registers only. There is no combinational path from `imem_rdata` to `dec_*`.
- The only combinational input-to-output paths are `redirect`/`redirect_pc` → `imem_req`/`imem_addr`.

## Structure
- Shared `cpu_pkg` holds:
  - `PC_W`=16 and `INSTR_W`=16.
  - Default `PC_STEP`=4.
  - The typedef `fetch_entry_t` {pc, instr}, which is reused by the decode-stage pipeline registers.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, DEPTH entries, with push/pop/clear and a count output. `fetch_queue` contains the PC, the in-flight tracking and the request logic.

## Test plan
- Reset release, `dec_ready`=1, imem returns 16'h1000+addr/4:
  - Requests at 0x0000, 0x0004, 0x0008… on consecutive cycles.
  - `dec_valid` rises in cycle 2 with pc 0x0000, instr 0x1000.
  - One pop per cycle after that.
- Backpressure, `dec_ready`=0, DEPTH=4:
  - Exactly 4 requests (0x0–0xC), then `imem_req`=0 from cycle 4, `count`=4.
  - Raise `dec_ready`: first pop is pc 0x0. Next request is at 0x10, one cycle after the first pop.
- Redirect while full with a read in flight, `redirect_pc`=0x0200:
  - Same cycle: `imem_addr`=0x0200.
  - Next cycle: `dec_valid`=0, `count`=0.
  - Cycle after: `dec_pc`=0x0200. No stale entry is ever popped.
- Simultaneous redirect and pop: head is not counted as retired. The `redirect_pc` entry is the next one delivered.
- Wrap: redirect to 0xFFFC, so requests go 0xFFFC, then 0x0000; pointers wrap after DEPTH pushes with correct order.
- Assert `reset` asynchronously mid-stream (off clock edge): all outputs clear immediately. Restart fetches at RESET_PC in cycle 0 after release.
